// File: rtl/vector_mcu_pkg.sv
// Shared types for the vector memory-control-unit request front end:
// element width codes, FSM states, addressing modes and the width-to-size map.
package vector_mcu_pkg;

  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_ISSUE = 2'd1,
    LD_DRAIN = 2'd2,
    ST_ISSUE = 2'd3
  } mcu_state_e;

  typedef enum logic [1:0] {
    UNIT    = 2'd0,
    STRIDED = 2'd1,
    INDEXED = 2'd2
  } addr_mode_e;

  // Memory request size: 0=byte, 1=half, 2=word; unknown codes act as 32-bit.
  function automatic logic [1:0] size_from_width(input logic [2:0] width);
    case (width)
      W8:      return 2'd0;
      W16:     return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/mcu_addr_gen.sv
// Element address generator. Holds the running address for unit and strided
// walks and forms base + index for indexed accesses.
module mcu_addr_gen
  import vector_mcu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] base_addr,
  input  logic [31:0] stride,
  input  logic [1:0]  mode,
  input  logic [1:0]  size,
  input  logic [31:0] idx_data,
  output logic [31:0] addr
);

  logic [31:0] cur_addr;
  logic [31:0] base_q;
  logic [31:0] stride_q;
  logic [31:0] step;

  // Step between consecutive elements: stride when strided, element bytes otherwise.
  always_comb begin
    step = 32'd4;
    if (mode == STRIDED) begin
      step = stride_q;
    end else begin
      case (size)
        2'd0:    step = 32'd1;
        2'd1:    step = 32'd2;
        default: step = 32'd4;
      endcase
    end
  end

  // Latch base/stride on acceptance, advance the running address on each handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr <= '0;
      base_q   <= '0;
      stride_q <= '0;
    end else if (load) begin
      cur_addr <= base_addr;
      base_q   <= base_addr;
      stride_q <= stride;
    end else if (advance) begin
      cur_addr <= cur_addr + step;
    end
  end

  assign addr = (mode == INDEXED) ? (base_q + idx_data) : cur_addr;

endmodule

// File: rtl/mcu_req_frontend.sv
// Request front end between the scheduler's load/store issue port and the
// memory port: accepts one vector access, emits vl element requests and
// counts load responses until the load is fully buffered.
//
// Handshakes (issue port, index port, memory request port): a transfer happens
// on a rising edge where valid and ready are both high. Valid never depends on
// ready, and once mem_req_vld_o is raised it and its payload (addr/size/we)
// hold until the transfer, except on reset.
module mcu_req_frontend
  import vector_mcu_pkg::*;
#(
  parameter  int VLEN = 4096,
  localparam int VL_W = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mcu_ld_vld_i,
  input  logic            mcu_st_vld_i,
  input  logic [31:0]     mcu_base_addr_i,
  input  logic [31:0]     mcu_stride_i,
  input  logic [2:0]      mcu_data_width_i,
  input  logic            mcu_idx_ld_st_i,
  input  logic            mcu_strided_ld_st_i,
  input  logic            mcu_unit_ld_st_i,
  input  logic [VL_W-1:0] vl_i,
  output logic            mcu_ld_rdy_o,
  output logic            mcu_st_rdy_o,
  output logic            mcu_ld_buffered_o,
  input  logic            idx_vld_i,
  input  logic [31:0]     idx_data_i,
  output logic            idx_rdy_o,
  output logic            mem_req_vld_o,
  input  logic            mem_req_rdy_i,
  output logic [31:0]     mem_req_addr_o,
  output logic            mem_req_we_o,
  output logic [1:0]      mem_req_size_o,
  input  logic            mem_rsp_vld_i
);

  localparam logic [VL_W-1:0] ONE = VL_W'(1);

  mcu_state_e      state;
  addr_mode_e      mode_q;
  addr_mode_e      mode_next;
  logic [1:0]      size_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] iss_cnt;
  logic [VL_W-1:0] rsp_cnt;
  logic [VL_W-1:0] rsp_next;
  logic            ld_buffered_q;

  logic idle, issuing, is_idx;
  logic ld_acc, st_acc, accept;
  logic hs, last_hs, rsp_in, all_rsp;

  assign idle    = (state == IDLE);
  assign issuing = (state == LD_ISSUE) || (state == ST_ISSUE);
  assign is_idx  = (mode_q == INDEXED);

  // Load wins over store when both are offered in IDLE.
  assign mcu_ld_rdy_o = idle;
  assign mcu_st_rdy_o = idle & ~mcu_ld_vld_i;
  assign ld_acc       = mcu_ld_vld_i & mcu_ld_rdy_o;
  assign st_acc       = mcu_st_vld_i & mcu_st_rdy_o;
  assign accept       = ld_acc | st_acc;

  // Indexed accesses can only issue while an index element is on offer.
  assign mem_req_vld_o  = issuing & (~is_idx | idx_vld_i);
  assign idx_rdy_o      = issuing & is_idx & mem_req_rdy_i;
  assign mem_req_we_o   = (state == ST_ISSUE);
  assign mem_req_size_o = size_q;

  assign hs       = mem_req_vld_o & mem_req_rdy_i;
  assign last_hs  = hs & (iss_cnt == (vl_q - ONE));
  assign rsp_in   = mem_rsp_vld_i & ((state == LD_ISSUE) || (state == LD_DRAIN));
  assign rsp_next = rsp_cnt + (rsp_in ? ONE : '0);
  assign all_rsp  = (rsp_next == vl_q);

  assign mcu_ld_buffered_o = ld_buffered_q;

  // Mode priority at acceptance: indexed, then strided, else unit stride.
  always_comb begin
    mode_next = UNIT;
    if (mcu_idx_ld_st_i)          mode_next = INDEXED;
    else if (mcu_strided_ld_st_i) mode_next = STRIDED;
    else if (mcu_unit_ld_st_i)    mode_next = UNIT;
  end

  // Control FSM with issue/response counters and the buffered flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      mode_q        <= UNIT;
      size_q        <= 2'd0;
      vl_q          <= '0;
      iss_cnt       <= '0;
      rsp_cnt       <= '0;
      ld_buffered_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q  <= mode_next;
            size_q  <= size_from_width(mcu_data_width_i);
            vl_q    <= vl_i;
            iss_cnt <= '0;
            rsp_cnt <= '0;
            if (vl_i != '0) begin
              if (ld_acc) begin
                state         <= LD_ISSUE;
                ld_buffered_q <= 1'b0;
              end else begin
                state <= ST_ISSUE;
              end
            end
          end
        end
        LD_ISSUE: begin
          rsp_cnt <= rsp_next;
          if (hs) iss_cnt <= iss_cnt + ONE;
          if (last_hs) begin
            if (all_rsp) begin
              state         <= IDLE;
              ld_buffered_q <= 1'b1;
            end else begin
              state <= LD_DRAIN;
            end
          end
        end
        LD_DRAIN: begin
          rsp_cnt <= rsp_next;
          if (all_rsp) begin
            state         <= IDLE;
            ld_buffered_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hs) iss_cnt <= iss_cnt + ONE;
          if (last_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mcu_addr_gen u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .advance   (hs),
    .base_addr (mcu_base_addr_i),
    .stride    (mcu_stride_i),
    .mode      (mode_q),
    .size      (size_q),
    .idx_data  (idx_data_i),
    .addr      (mem_req_addr_o)
  );

endmodule

// File: tb/tb_mcu_req_frontend.sv
// Bench for mcu_req_frontend: scenario tasks drive the issue/index/response
// ports, a request scoreboard holds expected {we,size,addr} words.
module tb_mcu_req_frontend;

  localparam int VLEN = 4096;
  localparam int VL_W = $clog2(VLEN) + 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            mcu_ld_vld_i, mcu_st_vld_i;
  logic [31:0]     mcu_base_addr_i, mcu_stride_i;
  logic [2:0]      mcu_data_width_i;
  logic            mcu_idx_ld_st_i, mcu_strided_ld_st_i, mcu_unit_ld_st_i;
  logic [VL_W-1:0] vl_i;
  logic            mcu_ld_rdy_o, mcu_st_rdy_o, mcu_ld_buffered_o;
  logic            idx_vld_i;
  logic [31:0]     idx_data_i;
  logic            idx_rdy_o;
  logic            mem_req_vld_o, mem_req_rdy_i;
  logic [31:0]     mem_req_addr_o;
  logic            mem_req_we_o;
  logic [1:0]      mem_req_size_o;
  logic            mem_rsp_vld_i;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  logic [34:0] exp_q[$];

  mcu_req_frontend #(.VLEN(VLEN)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .mcu_ld_vld_i        (mcu_ld_vld_i),
    .mcu_st_vld_i        (mcu_st_vld_i),
    .mcu_base_addr_i     (mcu_base_addr_i),
    .mcu_stride_i        (mcu_stride_i),
    .mcu_data_width_i    (mcu_data_width_i),
    .mcu_idx_ld_st_i     (mcu_idx_ld_st_i),
    .mcu_strided_ld_st_i (mcu_strided_ld_st_i),
    .mcu_unit_ld_st_i    (mcu_unit_ld_st_i),
    .vl_i                (vl_i),
    .mcu_ld_rdy_o        (mcu_ld_rdy_o),
    .mcu_st_rdy_o        (mcu_st_rdy_o),
    .mcu_ld_buffered_o   (mcu_ld_buffered_o),
    .idx_vld_i           (idx_vld_i),
    .idx_data_i          (idx_data_i),
    .idx_rdy_o           (idx_rdy_o),
    .mem_req_vld_o       (mem_req_vld_o),
    .mem_req_rdy_i       (mem_req_rdy_i),
    .mem_req_addr_o      (mem_req_addr_o),
    .mem_req_we_o        (mem_req_we_o),
    .mem_req_size_o      (mem_req_size_o),
    .mem_rsp_vld_i       (mem_rsp_vld_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor (samples on falling edge) ----------------
  task automatic monitor();
    logic [34:0] obs, exp_w, stall_word;
    logic stall_prev;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 1'b0;
      end else begin
        obs = {mem_req_we_o, mem_req_size_o, mem_req_addr_o};
        if (stall_prev) begin
          checks++;
          if (!mem_req_vld_o || obs !== stall_word) begin
            failures++;
            $display("FAIL stall_hold: got vld=%0b word=%h, required vld=1 word=%h",
                     mem_req_vld_o, obs, stall_word);
          end
        end
        if (mem_req_vld_o && mem_req_rdy_i) begin
          hs_count++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_req: got word=%h, required no request", obs);
          end else begin
            exp_w = exp_q.pop_front();
            if (obs !== exp_w) begin
              failures++;
              $display("FAIL req_word: got we/size/addr=%h, required %h", obs, exp_w);
            end
          end
        end
        stall_prev = mem_req_vld_o && !mem_req_rdy_i;
        stall_word = obs;
      end
    end
  endtask

  task automatic watchdog();
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_seq(input logic we, input logic [1:0] sz, input logic [31:0] base,
                          input logic [31:0] step, input int n);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({we, sz, a});
      a = a + step;
    end
  endtask

  task automatic issue(input logic ld, input logic [31:0] base, input logic [31:0] stride,
                       input logic [2:0] w, input logic idx, input logic strd, input logic unit,
                       input logic [VL_W-1:0] vl);
    int n;
    mcu_base_addr_i     = base;
    mcu_stride_i        = stride;
    mcu_data_width_i    = w;
    mcu_idx_ld_st_i     = idx;
    mcu_strided_ld_st_i = strd;
    mcu_unit_ld_st_i    = unit;
    vl_i                = vl;
    mcu_ld_vld_i        = ld;
    mcu_st_vld_i        = ~ld;
    #1;
    n = 0;
    while (!(ld ? mcu_ld_rdy_o : mcu_st_rdy_o) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!(ld ? mcu_ld_rdy_o : mcu_st_rdy_o)) begin
      failures++;
      $display("FAIL issue_ready: got rdy=0 after %0d cycles, required rdy=1", n);
    end
    tick();
    mcu_ld_vld_i = 1'b0;
    mcu_st_vld_i = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d requests outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rsp_vld_i = 1'b1;
      tick();
      mem_rsp_vld_i = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mem_req_vld_o, idx_rdy_o, mcu_ld_buffered_o, mcu_ld_rdy_o, mcu_st_rdy_o} !== 5'b00111) begin
      failures++;
      $display("FAIL reset_outputs: got vld,idx_rdy,buf,ld_rdy,st_rdy=%b, required 00111",
               {mem_req_vld_o, idx_rdy_o, mcu_ld_buffered_o, mcu_ld_rdy_o, mcu_st_rdy_o});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_unit_load();
    mem_req_rdy_i = 1'b1;
    push_seq(1'b0, 2'd2, 32'h1000, 32'd4, 4);
    issue(1'b1, 32'h1000, 32'd0, 3'b110, 1'b0, 1'b0, 1'b1, VL_W'(4));
    checks++;
    if (mcu_ld_buffered_o !== 1'b0) begin
      failures++;
      $display("FAIL t1_buf_drop: got %b, required 0", mcu_ld_buffered_o);
    end
    wait_drain("t1", 20);
    checks++;
    if (mcu_ld_rdy_o !== 1'b0 || mem_req_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL t1_drain_state: got ld_rdy=%b vld=%b, required 0 0", mcu_ld_rdy_o, mem_req_vld_o);
    end
    for (int i = 0; i < 3; i++) begin
      send_rsp(1);
      checks++;
      if (mcu_ld_buffered_o !== 1'b0) begin
        failures++;
        $display("FAIL t1_buf_early: got %b after %0d rsps, required 0", mcu_ld_buffered_o, i + 1);
      end
    end
    send_rsp(1);
    checks++;
    if (mcu_ld_buffered_o !== 1'b1 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL t1_buf_done: got buf=%b ld_rdy=%b, required 1 1", mcu_ld_buffered_o, mcu_ld_rdy_o);
    end
  endtask

  task automatic test_strided_store();
    mem_req_rdy_i = 1'b1;
    push_seq(1'b1, 2'd1, 32'h2000, 32'hFFFF_FFF8, 3);
    issue(1'b0, 32'h2000, 32'hFFFF_FFF8, 3'b101, 1'b0, 1'b1, 1'b0, VL_W'(3));
    checks++;
    if (mcu_st_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL t2_busy: got st_rdy=%b, required 0", mcu_st_rdy_o);
    end
    wait_drain("t2", 20);
    checks++;
    if (mcu_st_rdy_o !== 1'b1 || mem_req_vld_o !== 1'b0 || mcu_ld_buffered_o !== 1'b1) begin
      failures++;
      $display("FAIL t2_done: got st_rdy=%b vld=%b buf=%b, required 1 0 1",
               mcu_st_rdy_o, mem_req_vld_o, mcu_ld_buffered_o);
    end
  endtask

  task automatic test_indexed_load();
    logic [31:0] idx_list [3];
    idx_list[0] = 32'd4;
    idx_list[1] = 32'd0;
    idx_list[2] = 32'd12;
    mem_req_rdy_i = 1'b1;
    idx_vld_i     = 1'b0;
    // all three mode flags set: indexed has priority
    issue(1'b1, 32'h100, 32'd64, 3'b110, 1'b1, 1'b1, 1'b1, VL_W'(3));
    repeat (2) begin
      checks++;
      if (mem_req_vld_o !== 1'b0) begin
        failures++;
        $display("FAIL t3_gap_start: got vld=%b, required 0", mem_req_vld_o);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idx_vld_i  = 1'b1;
      idx_data_i = idx_list[i];
      exp_q.push_back({1'b0, 2'd2, 32'h100 + idx_list[i]});
      if (i == 1) mem_rsp_vld_i = 1'b1;
      #1;
      checks++;
      if (idx_rdy_o !== 1'b1 || mem_req_vld_o !== 1'b1) begin
        failures++;
        $display("FAIL t3_idx_take: got idx_rdy=%b vld=%b, required 1 1", idx_rdy_o, mem_req_vld_o);
      end
      tick();
      idx_vld_i     = 1'b0;
      mem_rsp_vld_i = 1'b0;
      idx_data_i    = $urandom_range(0, 255);
      #1;
      checks++;
      if (mem_req_vld_o !== 1'b0) begin
        failures++;
        $display("FAIL t3_gap: got vld=%b without idx_vld, required 0", mem_req_vld_o);
      end
      tick();
    end
    wait_drain("t3", 5);
    send_rsp(1);
    checks++;
    if (mcu_ld_buffered_o !== 1'b0) begin
      failures++;
      $display("FAIL t3_buf_early: got %b after 2 of 3 rsps, required 0", mcu_ld_buffered_o);
    end
    send_rsp(1);
    checks++;
    if (mcu_ld_buffered_o !== 1'b1) begin
      failures++;
      $display("FAIL t3_buf_done: got %b, required 1", mcu_ld_buffered_o);
    end
  endtask

  task automatic test_backpressure();
    int hs_base;
    hs_base = hs_count;
    mem_req_rdy_i = 1'b1;
    push_seq(1'b0, 2'd0, 32'h3000, 32'd1, 2);
    issue(1'b1, 32'h3000, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, VL_W'(2));
    tick();
    mem_req_rdy_i = 1'b0;
    #1;
    checks++;
    if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 32'h3001) begin
      failures++;
      $display("FAIL t4_stall_addr: got vld=%b addr=%h, required 1 00003001", mem_req_vld_o, mem_req_addr_o);
    end
    tick();
    mem_req_rdy_i = 1'b1;
    tick();
    mem_req_rdy_i = 1'b0;
    tick();
    checks++;
    if (hs_count - hs_base !== 2 || mem_req_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL t4_hs_count: got %0d handshakes vld=%b, required 2 0", hs_count - hs_base, mem_req_vld_o);
    end
    send_rsp(2);
    checks++;
    if (mcu_ld_buffered_o !== 1'b1) begin
      failures++;
      $display("FAIL t4_buf_done: got %b, required 1", mcu_ld_buffered_o);
    end
    mem_req_rdy_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    int hs_base;
    mem_req_rdy_i = 1'b1;
    push_seq(1'b0, 2'd2, 32'h4000, 32'd4, 2);
    push_seq(1'b1, 2'd2, 32'h4000, 32'd4, 2);
    mcu_base_addr_i     = 32'h4000;
    mcu_stride_i        = 32'd0;
    mcu_data_width_i    = 3'b110;
    mcu_idx_ld_st_i     = 1'b0;
    mcu_strided_ld_st_i = 1'b0;
    mcu_unit_ld_st_i    = 1'b1;
    vl_i                = VL_W'(2);
    mcu_ld_vld_i        = 1'b1;
    mcu_st_vld_i        = 1'b1;
    #1;
    checks++;
    if (mcu_st_rdy_o !== 1'b0 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_priority: got ld_rdy=%b st_rdy=%b, required 1 0", mcu_ld_rdy_o, mcu_st_rdy_o);
    end
    tick();
    mcu_ld_vld_i = 1'b0;
    checks++;
    if (mcu_st_rdy_o !== 1'b0 || mem_req_we_o !== 1'b0) begin
      failures++;
      $display("FAIL t5_st_blocked: got st_rdy=%b we=%b, required 0 0", mcu_st_rdy_o, mem_req_we_o);
    end
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      tick();
      n++;
    end
    send_rsp(1);
    checks++;
    if (mcu_st_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL t5_st_wait_drain: got st_rdy=%b, required 0", mcu_st_rdy_o);
    end
    send_rsp(1);
    checks++;
    if (mcu_st_rdy_o !== 1'b1 || mcu_ld_buffered_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_st_ready: got st_rdy=%b buf=%b, required 1 1", mcu_st_rdy_o, mcu_ld_buffered_o);
    end
    tick();
    mcu_st_vld_i = 1'b0;
    wait_drain("t5", 20);
    checks++;
    if (mcu_st_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL t5_st_done: got st_rdy=%b, required 1", mcu_st_rdy_o);
    end
    // zero-length load and store: no requests, no state change
    hs_base = hs_count;
    issue(1'b1, 32'h7000, 32'd0, 3'b110, 1'b0, 1'b0, 1'b1, VL_W'(0));
    issue(1'b0, 32'h7100, 32'd0, 3'b110, 1'b0, 1'b0, 1'b1, VL_W'(0));
    repeat (3) begin
      checks++;
      if (mem_req_vld_o !== 1'b0 || mcu_ld_buffered_o !== 1'b1 || mcu_ld_rdy_o !== 1'b1) begin
        failures++;
        $display("FAIL t5_vl0: got vld=%b buf=%b ld_rdy=%b, required 0 1 1",
                 mem_req_vld_o, mcu_ld_buffered_o, mcu_ld_rdy_o);
      end
      tick();
    end
    checks++;
    if (hs_count !== hs_base) begin
      failures++;
      $display("FAIL t5_vl0_hs: got %0d handshakes, required 0", hs_count - hs_base);
    end
  endtask

  task automatic test_reset_mid_drain();
    mem_req_rdy_i = 1'b1;
    push_seq(1'b0, 2'd2, 32'h5000, 32'd4, 4);
    issue(1'b1, 32'h5000, 32'd0, 3'b110, 1'b0, 1'b0, 1'b1, VL_W'(4));
    wait_drain("t6a", 20);
    send_rsp(2);
    checks++;
    if (mcu_ld_buffered_o !== 1'b0) begin
      failures++;
      $display("FAIL t6_pre_reset: got buf=%b, required 0", mcu_ld_buffered_o);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({mem_req_vld_o, mcu_ld_buffered_o, mcu_ld_rdy_o, mcu_st_rdy_o} !== 4'b0111) begin
      failures++;
      $display("FAIL t6_reset: got vld,buf,ld_rdy,st_rdy=%b, required 0111",
               {mem_req_vld_o, mcu_ld_buffered_o, mcu_ld_rdy_o, mcu_st_rdy_o});
    end
    rstn = 1'b1;
    tick();
    send_rsp(2);
    push_seq(1'b0, 2'd0, 32'h6000, 32'd1, 2);
    issue(1'b1, 32'h6000, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, VL_W'(2));
    wait_drain("t6b", 20);
    send_rsp(1);
    checks++;
    if (mcu_ld_buffered_o !== 1'b0) begin
      failures++;
      $display("FAIL t6_late_ignored: got buf=%b after 1 of 2 rsps, required 0", mcu_ld_buffered_o);
    end
    send_rsp(1);
    checks++;
    if (mcu_ld_buffered_o !== 1'b1 || mcu_ld_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL t6_new_done: got buf=%b ld_rdy=%b, required 1 1", mcu_ld_buffered_o, mcu_ld_rdy_o);
    end
  endtask

  // ---------------- main sequence and final report ----------------
  initial begin
    rstn                = 1'b0;
    mcu_ld_vld_i        = 1'b0;
    mcu_st_vld_i        = 1'b0;
    mcu_base_addr_i     = '0;
    mcu_stride_i        = '0;
    mcu_data_width_i    = 3'b000;
    mcu_idx_ld_st_i     = 1'b0;
    mcu_strided_ld_st_i = 1'b0;
    mcu_unit_ld_st_i    = 1'b0;
    vl_i                = '0;
    idx_vld_i           = 1'b0;
    idx_data_i          = '0;
    mem_req_rdy_i       = 1'b0;
    mem_rsp_vld_i       = 1'b0;
    fork
      monitor();
      watchdog();
    join_none
    test_reset();
    test_unit_load();
    test_strided_store();
    test_indexed_load();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: got %0d expected requests left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
